// File: rtl/execute_stage.sv
// Execute stage: decodes the one-hot ID_EX bundle, runs the ALU, resolves
// branches with wrong-path squash, iterates a 4-cycle multiply and latches halt.
module execute_stage #(
  parameter int BRANCH_SQUASH = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [175:0] ID_EX,
  input  logic         id_valid,
  output logic         ex_stall,
  output logic [71:0]  EX_MEM,
  output logic         branch_taken,
  output logic [31:0]  branch_target,
  output logic         halted
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MUL,
    ST_HALT
  } state_t;

  state_t state_reg, state_next;

  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm;
  logic [15:0] op;
  logic [4:0]  rd;
  logic [4:0]  rt_idx;
  logic [4:0]  shamt;

  assign instr   = ID_EX[31:0];
  assign pc      = ID_EX[63:32];
  assign rs_data = ID_EX[95:64];
  assign rt_data = ID_EX[127:96];
  assign imm     = ID_EX[159:128];
  assign op      = ID_EX[175:160];
  assign rd      = instr[15:11];
  assign rt_idx  = instr[20:16];
  assign shamt   = instr[10:6];

  // Lowest set opcode bit wins when the decoder hands over several.
  logic [15:0] op_sel;
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pri
      if (gi == 0) begin : g_first
        assign op_sel[gi] = op[0];
      end else begin : g_rest
        assign op_sel[gi] = op[gi] & ~(|op[gi-1:0]);
      end
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = ^{instr[31:21], instr[5:0], op_sel[15:14]};

  logic [1:0]  squash_reg, squash_next;
  logic [71:0] em_reg, em_next;
  logic        br_taken_reg;
  logic [31:0] br_target_reg;

  logic [31:0] mul_a_reg, mul_b_reg, mul_acc_reg, mul_pc_reg;
  logic [4:0]  mul_rd_reg;
  logic [1:0]  mul_k_reg;
  logic        mul_start;

  logic        accept;
  logic        live;
  logic        squashing;
  logic [31:0] target;

  assign ex_stall  = (state_reg == ST_MUL) | (state_reg == ST_HALT);
  assign halted    = (state_reg == ST_HALT);
  assign accept    = id_valid & ~ex_stall & ~halted;
  assign squashing = accept & (squash_reg != 2'd0);
  assign live      = accept & (squash_reg == 2'd0);
  assign target    = pc + 32'd4 + {imm[29:0], 2'b00};

  // Single-cycle ALU decode.
  logic [31:0] alu_result;
  logic [4:0]  alu_dest;
  logic        alu_we;
  logic        alu_valid;
  logic        alu_halt;
  logic        alu_taken;
  logic        is_mul;
  logic        is_hlt;

  always_comb begin
    alu_result = 32'd0;
    alu_dest   = 5'd0;
    alu_we     = 1'b0;
    alu_valid  = 1'b0;
    alu_halt   = 1'b0;
    alu_taken  = 1'b0;
    is_mul     = 1'b0;
    is_hlt     = 1'b0;
    case (1'b1)
      op_sel[0]: begin
        alu_result = rs_data + rt_data;
        alu_dest   = rd;
        alu_we     = 1'b1;
        alu_valid  = 1'b1;
      end
      op_sel[1]: begin
        alu_result = rs_data - rt_data;
        alu_dest   = rd;
        alu_we     = 1'b1;
        alu_valid  = 1'b1;
      end
      op_sel[2]: begin
        alu_result = imm;
        alu_dest   = rt_idx;
        alu_we     = 1'b1;
        alu_valid  = 1'b1;
      end
      op_sel[3]: begin
        alu_result = rs_data << shamt;
        alu_dest   = rd;
        alu_we     = 1'b1;
        alu_valid  = 1'b1;
      end
      op_sel[4]: begin
        alu_result = rs_data >> shamt;
        alu_dest   = rd;
        alu_we     = 1'b1;
        alu_valid  = 1'b1;
      end
      op_sel[5]: begin
        alu_result = rs_data & rt_data;
        alu_dest   = rd;
        alu_we     = 1'b1;
        alu_valid  = 1'b1;
      end
      op_sel[6]: begin
        alu_result = rs_data | rt_data;
        alu_dest   = rd;
        alu_we     = 1'b1;
        alu_valid  = 1'b1;
      end
      op_sel[7]: begin
        alu_result = rs_data ^ rt_data;
        alu_dest   = rd;
        alu_we     = 1'b1;
        alu_valid  = 1'b1;
      end
      op_sel[8]: begin
        alu_result = target;
        alu_valid  = 1'b1;
        alu_taken  = 1'b1;
      end
      op_sel[9]: begin
        alu_result = target;
        alu_valid  = 1'b1;
        alu_taken  = (rs_data != rt_data);
      end
      op_sel[10]: begin
        alu_result = rs_data;
        alu_dest   = rd;
        alu_we     = 1'b1;
        alu_valid  = 1'b1;
      end
      op_sel[11]: begin
        alu_result = rs_data + imm;
        alu_dest   = rt_idx;
        alu_we     = 1'b1;
        alu_valid  = 1'b1;
      end
      op_sel[12]: begin
        is_mul = 1'b1;
      end
      op_sel[13]: begin
        alu_valid = 1'b1;
        alu_halt  = 1'b1;
        is_hlt    = 1'b1;
      end
      default: begin
        alu_valid = 1'b0;
      end
    endcase
  end

  // One multiplier byte per cycle: acc += (a * b[8k+7:8k]) << 8k.
  logic [7:0]  mul_byte;
  logic [31:0] mul_partial;
  logic [31:0] mul_acc_next;

  always_comb begin
    mul_byte     = 8'(mul_b_reg >> {mul_k_reg, 3'b000});
    mul_partial  = (mul_a_reg * {24'd0, mul_byte}) << {mul_k_reg, 3'b000};
    mul_acc_next = mul_acc_reg + mul_partial;
  end

  logic br_pulse;

  always_comb begin
    state_next  = state_reg;
    squash_next = squash_reg;
    em_next     = 72'd0;
    br_pulse    = 1'b0;
    mul_start   = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (squashing) begin
          squash_next = squash_reg - 2'd1;
        end else if (live) begin
          if (is_mul) begin
            mul_start  = 1'b1;
            state_next = ST_MUL;
          end else begin
            if (alu_valid) begin
              em_next = {alu_halt, 1'b1, alu_we, alu_dest, pc, alu_result};
            end
            if (is_hlt) begin
              state_next = ST_HALT;
            end
            if (alu_taken) begin
              br_pulse    = 1'b1;
              squash_next = 2'(BRANCH_SQUASH);
            end
          end
        end
      end
      ST_MUL: begin
        if (mul_k_reg == 2'd3) begin
          em_next    = {1'b0, 1'b1, 1'b1, mul_rd_reg, mul_pc_reg, mul_acc_next};
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_RUN;
      squash_reg    <= 2'd0;
      em_reg        <= 72'd0;
      br_taken_reg  <= 1'b0;
      br_target_reg <= 32'd0;
      mul_a_reg     <= 32'd0;
      mul_b_reg     <= 32'd0;
      mul_acc_reg   <= 32'd0;
      mul_pc_reg    <= 32'd0;
      mul_rd_reg    <= 5'd0;
      mul_k_reg     <= 2'd0;
    end else begin
      state_reg    <= state_next;
      squash_reg   <= squash_next;
      em_reg       <= em_next;
      br_taken_reg <= br_pulse;
      if (br_pulse) begin
        br_target_reg <= target;
      end
      if (mul_start) begin
        mul_a_reg   <= rs_data;
        mul_b_reg   <= rt_data;
        mul_acc_reg <= 32'd0;
        mul_pc_reg  <= pc;
        mul_rd_reg  <= rd;
        mul_k_reg   <= 2'd0;
      end else if (state_reg == ST_MUL) begin
        mul_acc_reg <= mul_acc_next;
        mul_k_reg   <= mul_k_reg + 2'd1;
      end
    end
  end

  assign EX_MEM        = em_reg;
  assign branch_taken  = br_taken_reg;
  assign branch_target = br_target_reg;

endmodule
